rgb_to_grayscale: RTL and testbench

RGB_TO_GRAYSCALE -- requirements
Module: rgb_to_grayscale

---
 rtl/rgb_to_grayscale.sv | 83 ++++++++
 tb/tb_rgb_to_grayscale.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_grayscale.sv
// rgb_to_grayscale
//   Two-stage pipelined RGB -> luminance converter.
//   Y = min(255, (COEF_R*R + COEF_G*G + COEF_B*B + (ROUND ? 128 : 0)) >> 8)
//
// Ports
//   clk         : rising-edge clock for all state
//   rst         : synchronous active-high reset, clears both stages
//   red_i       : 8-bit unsigned red component
//   green_i     : 8-bit unsigned green component
//   blue_i      : 8-bit unsigned blue component
//   done_i      : input-valid strobe; RGB is sampled on edges where it is 1
//   grayscale_o : registered 8-bit luminance result
//   done_o      : registered output-valid strobe, done_i delayed by two edges
//
// Stage 1 registers the three 16-bit products plus a valid bit.
// Stage 2 sums, rounds, shifts and saturates into grayscale_o.
// There is no backpressure; a new sample can be accepted every cycle.
module rgb_to_grayscale #(
  parameter logic [7:0] COEF_R = 8'd77,
  parameter logic [7:0] COEF_G = 8'd150,
  parameter logic [7:0] COEF_B = 8'd29,
  parameter bit         ROUND  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] red_i,
  input  logic [7:0] green_i,
  input  logic [7:0] blue_i,
  input  logic       done_i,
  output logic [7:0] grayscale_o,
  output logic       done_o
);

  localparam logic [17:0] RND_TERM = ROUND ? 18'd128 : 18'd0;

  // Stage 1 state
  logic [15:0] prod_r;
  logic [15:0] prod_g;
  logic [15:0] prod_b;
  logic        valid_s1;

  // Stage 2 combinational datapath
  logic [17:0] sum;
  logic [17:0] shifted;
  logic [7:0]  sat;

  // Products hold their previous values while done_i is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_r   <= '0;
      prod_g   <= '0;
      prod_b   <= '0;
      valid_s1 <= 1'b0;
    end else begin
      valid_s1 <= done_i;
      if (done_i) begin
        prod_r <= 16'(COEF_R) * 16'(red_i);
        prod_g <= 16'(COEF_G) * 16'(green_i);
        prod_b <= 16'(COEF_B) * 16'(blue_i);
      end
    end
  end

  // 3 * 65025 + 128 < 2^18, so the 18-bit sum cannot overflow.
  always_comb begin
    sum     = 18'(prod_r) + 18'(prod_g) + 18'(prod_b) + RND_TERM;
    shifted = sum >> 8;
    sat     = (shifted > 18'd255) ? 8'hFF : shifted[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grayscale_o <= '0;
      done_o      <= 1'b0;
    end else begin
      done_o <= valid_s1;
      if (valid_s1) begin
        grayscale_o <= sat;
      end
    end
  end

endmodule

// File: tb/tb_rgb_to_grayscale.sv
// Testbench for rgb_to_grayscale: directed table vectors, hand-written
// multi-cycle sequences and randomized traffic against a queue-based
// reference model. A second instance with heavy coefficients and no
// rounding exercises saturation.
module tb_rgb_to_grayscale;

  localparam int unsigned SAT_C = 255;

  logic       clk;
  logic       rst;
  logic [7:0] red_i;
  logic [7:0] green_i;
  logic [7:0] blue_i;
  logic       done_i;
  logic [7:0] grayscale_o;
  logic       done_o;
  logic [7:0] grayscale_s;
  logic       done_s;

  rgb_to_grayscale dut (
    .clk         (clk),
    .rst         (rst),
    .red_i       (red_i),
    .green_i     (green_i),
    .blue_i      (blue_i),
    .done_i      (done_i),
    .grayscale_o (grayscale_o),
    .done_o      (done_o)
  );

  rgb_to_grayscale #(
    .COEF_R (8'd255),
    .COEF_G (8'd255),
    .COEF_B (8'd255),
    .ROUND  (1'b0)
  ) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .red_i       (red_i),
    .green_i     (green_i),
    .blue_i      (blue_i),
    .done_i      (done_i),
    .grayscale_o (grayscale_s),
    .done_o      (done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [7:0]  val;
  } pend_t;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  pend_t       q0[$];
  pend_t       q1[$];
  logic [7:0]  exp0;
  logic [7:0]  exp1;
  int unsigned edge_cnt;
  int unsigned checks;
  int unsigned failures;

  function automatic logic [7:0] ref_y(input int unsigned cr, input int unsigned cg,
                                       input int unsigned cb, input bit rnd,
                                       input int unsigned r, input int unsigned g,
                                       input int unsigned b);
    int unsigned y;
    y = (cr * r + cg * g + cb * b + (rnd ? 128 : 0)) / 256;
    if (y > 255) y = 255;
    return 8'(y);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic drive(input logic d, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic rs);
    done_i  = d;
    red_i   = r;
    green_i = g;
    blue_i  = b;
    rst     = rs;
  endtask

  // Advance one clock edge, update the model with what was presented at
  // that edge, then compare both instances against it.
  task automatic tick();
    bit         acc;
    bit         ed0;
    bit         ed1;
    logic [7:0] y0;
    logic [7:0] y1;
    acc = (done_i === 1'b1) && (rst === 1'b0);
    y0  = ref_y(77, 150, 29, 1'b1, red_i, green_i, blue_i);
    y1  = ref_y(SAT_C, SAT_C, SAT_C, 1'b0, red_i, green_i, blue_i);
    @(posedge clk);
    edge_cnt++;
    if (rst === 1'b1) begin
      q0.delete();
      q1.delete();
      exp0 = '0;
      exp1 = '0;
    end else if (acc) begin
      q0.push_back('{due: edge_cnt + 1, val: y0});
      q1.push_back('{due: edge_cnt + 1, val: y1});
    end
    #1;
    ed0 = (q0.size() > 0) && (q0[0].due == edge_cnt);
    if (ed0) exp0 = q0.pop_front().val;
    ed1 = (q1.size() > 0) && (q1[0].due == edge_cnt);
    if (ed1) exp1 = q1.pop_front().val;
    check("done_o", 32'(done_o), 32'(ed0));
    check("grayscale_o", 32'(grayscale_o), 32'(exp0));
    check("sat_done_o", 32'(done_s), 32'(ed1));
    check("sat_grayscale_o", 32'(grayscale_s), 32'(exp1));
  endtask

  initial begin
    vec_t tbl[7];
    int unsigned n;
    bit d;
    bit rs;

    checks   = 0;
    failures = 0;
    edge_cnt = 0;
    exp0     = '0;
    exp1     = '0;

    tbl[0] = '{r: 8'd4,   g: 8'd2,   b: 8'd16,  y: 8'd4};
    tbl[1] = '{r: 8'd255, g: 8'd255, b: 8'd255, y: 8'd255};
    tbl[2] = '{r: 8'd0,   g: 8'd0,   b: 8'd0,   y: 8'd0};
    tbl[3] = '{r: 8'd255, g: 8'd0,   b: 8'd0,   y: 8'd77};
    tbl[4] = '{r: 8'd0,   g: 8'd255, b: 8'd0,   y: 8'd149};
    tbl[5] = '{r: 8'd0,   g: 8'd0,   b: 8'd255, y: 8'd29};
    tbl[6] = '{r: 8'd100, g: 8'd50,  b: 8'd200, y: 8'd82};

    // Reset
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    #1;
    repeat (3) tick();
    check("reset_gray", 32'(grayscale_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick();

    // Table vectors: one strobe, result visible after the second edge
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, tbl[i].r, tbl[i].g, tbl[i].b, 1'b0);
      tick();
      drive(1'b0, 8'd9, 8'd9, 8'd9, 1'b0);
      tick();
      check("tbl_gray", 32'(grayscale_o), 32'(tbl[i].y));
      check("tbl_done", 32'(done_o), 32'd1);
      tick();
      check("tbl_done_drop", 32'(done_o), 32'd0);
    end

    // Back-to-back primaries
    drive(1'b1, 8'd255, 8'd0, 8'd0, 1'b0);
    tick();
    drive(1'b1, 8'd0, 8'd255, 8'd0, 1'b0);
    tick();
    check("b2b_red", 32'(grayscale_o), 32'd77);
    drive(1'b1, 8'd0, 8'd0, 8'd255, 1'b0);
    tick();
    check("b2b_green", 32'(grayscale_o), 32'd149);
    check("b2b_green_done", 32'(done_o), 32'd1);
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick();
    check("b2b_blue", 32'(grayscale_o), 32'd29);
    check("b2b_blue_done", 32'(done_o), 32'd1);
    tick();

    // Inputs wiggle with done_i low: output holds
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      tick();
    end
    check("hold_gray", 32'(grayscale_o), 32'd29);
    check("hold_done", 32'(done_o), 32'd0);

    // Strobe followed by reset on the next edge: sample is flushed
    drive(1'b1, 8'd200, 8'd100, 8'd50, 1'b0);
    tick();
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    tick();
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    repeat (3) tick();
    check("flush_gray", 32'(grayscale_o), 32'd0);
    check("flush_done", 32'(done_o), 32'd0);

    // Reset and strobe on the same edge: reset wins
    drive(1'b1, 8'd255, 8'd255, 8'd255, 1'b1);
    tick();
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    repeat (3) tick();
    check("rst_prio_gray", 32'(grayscale_o), 32'd0);

    // First edge after reset with done_i=1 is accepted
    drive(1'b1, 8'd255, 8'd255, 8'd255, 1'b0);
    tick();
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    tick();
    check("first_after_rst", 32'(grayscale_o), 32'd255);
    check("first_after_rst_sat", 32'(grayscale_s), 32'd255);
    tick();

    // Randomized traffic with gaps and rare resets
    n = 0;
    while (n < 1000) begin
      d  = ($urandom_range(0, 99) < 60);
      rs = ($urandom_range(0, 299) == 0);
      drive(d, 8'($urandom), 8'($urandom), 8'($urandom), rs);
      if (d && !rs) n++;
      tick();
    end
    drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
    repeat (3) tick();
    check("drain_empty", 32'(q0.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
